// File: rtl/cim_pkg.sv
// Shared definitions for the CIM crossbar tile controller: FSM state
// encoding and width helpers used to size ports from the tile parameters.
package cim_pkg;

  typedef enum logic [1:0] {
    s_xbar_idle    = 2'd0,
    s_xbar_compute = 2'd1,
    s_xbar_done    = 2'd2
  } t_xbar_state;

  localparam int default_xbar_size     = 256;
  localparam int default_input_size    = 201;
  localparam int default_datatype_size = 8;

  // Width needed to index n items; never below 1 so a single-item
  // dimension still yields a legal one-bit signal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Address width for a crossbar of n rows.
  function automatic int addr_w(input int n);
    return idx_w(n);
  endfunction

  // Bit-plane index width for n-bit elements.
  function automatic int bit_w(input int n);
    return idx_w(n);
  endfunction

  // Width of a counter that must hold the value n itself.
  function automatic int cnt_w(input int n);
    return idx_w(n + 1);
  endfunction

endpackage

// File: rtl/cim_row_buffer.sv
// Row buffer for one crossbar tile: xbar_size elements of datatype_size bits,
// one write port and a bit-plane read port that returns bit i_bit_idx of
// every row at once.
// Optional feature: define CIM_XBAR_CLEAR_EN to make i_clear zero every row;
// without it i_clear is ignored and contents persist until reset.
module cim_row_buffer
  import cim_pkg::*;
#(
  parameter int xbar_size     = default_xbar_size,
  parameter int datatype_size = default_datatype_size
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_we,
  input  logic [addr_w(xbar_size)-1:0]      i_addr,
  input  logic [datatype_size-1:0]          i_data,
  input  logic                              i_clear,
  input  logic [bit_w(datatype_size)-1:0]   i_bit_idx,
  output logic [xbar_size-1:0]              o_plane
);

  logic [datatype_size-1:0] mem [xbar_size];

  // Storage: synchronous reset and optional clear, else single-port write.
  // NOTE: this array is reset on purpose (zeroed contents are observable on
  // the crossbar), which forces it into flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < xbar_size; r++) mem[r] <= '0;
    end
`ifdef CIM_XBAR_CLEAR_EN
    else if (i_clear) begin
      for (int r = 0; r < xbar_size; r++) mem[r] <= '0;
    end
`endif
    else if (i_we && (int'(i_addr) < xbar_size)) begin
      mem[i_addr] <= i_data;
    end
  end

`ifndef CIM_XBAR_CLEAR_EN
  logic unused_clear;
  assign unused_clear = i_clear;
`endif

  // Bit-plane read: gather the selected bit of every row.
  // NOTE: o_plane gets a full default before the loop so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    o_plane = '0;
    for (int r = 0; r < xbar_size; r++) o_plane[r] = mem[r][i_bit_idx];
  end

endmodule

// File: rtl/cim_xbar_ctrl.sv
// Responder-side controller for one CIM crossbar tile. Accepts element writes
// into the row buffer while idle, then on start streams the buffer into the
// crossbar bit-serially (LSB plane first) with busy raised, and pulses done.
// Optional feature: define CIM_XBAR_CLEAR_EN to clear the row buffer during
// the done state, so unwritten rows contribute 0 to the next compute.
module cim_xbar_ctrl
  import cim_pkg::*;
#(
  parameter int xbar_size     = default_xbar_size,
  parameter int input_size    = default_input_size,
  parameter int datatype_size = default_datatype_size
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_cim_we,
  input  logic [addr_w(xbar_size)-1:0]      i_cim_addr,
  input  logic [datatype_size-1:0]          i_data,
  input  logic                              i_start,
  output logic                              o_cim_busy,
  output logic                              o_xbar_en,
  output logic [xbar_size-1:0]              o_xbar_row,
  output logic [bit_w(datatype_size)-1:0]   o_bit_idx,
  output logic                              o_bit_last,
  output logic                              o_done,
  output logic [cnt_w(xbar_size)-1:0]       o_wr_count
);

  localparam int bw = bit_w(datatype_size);
  localparam int cw = cnt_w(xbar_size);
  localparam logic [bw-1:0] last_bit  = bw'(datatype_size - 1);
  localparam logic [cw-1:0] cnt_limit = cw'(input_size);

  t_xbar_state            state;
  logic [bw-1:0]          bit_cnt;
  logic                   wr_accept;
  logic                   buf_clear;
  logic [xbar_size-1:0]   plane;

  // Writes land only while idle; anything else from upstream is dropped.
  assign wr_accept = i_cim_we && (state == s_xbar_idle);
  assign buf_clear = (state == s_xbar_done);

  cim_row_buffer #(
    .xbar_size     (xbar_size),
    .datatype_size (datatype_size)
  ) u_row_buffer (
    .clk       (clk),
    .rst       (rst),
    .i_we      (wr_accept),
    .i_addr    (i_cim_addr),
    .i_data    (i_data),
    .i_clear   (buf_clear),
    .i_bit_idx (bit_cnt),
    .o_plane   (plane)
  );

  // FSM, bit counter, write counter and registered outputs. The outputs are
  // a one-cycle-late decode of the state, so plane k leaves the tile one
  // edge after the counter points at it and a write accepted with start is
  // already in the buffer when plane 0 is read.
  // NOTE: every assignment here is non-blocking so all registers update from
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= s_xbar_idle;
      bit_cnt    <= '0;
      o_cim_busy <= 1'b0;
      o_xbar_en  <= 1'b0;
      o_xbar_row <= '0;
      o_bit_idx  <= '0;
      o_bit_last <= 1'b0;
      o_done     <= 1'b0;
      o_wr_count <= '0;
    end else begin
      o_cim_busy <= (state != s_xbar_idle);
      o_xbar_en  <= (state == s_xbar_compute);
      o_xbar_row <= (state == s_xbar_compute) ? plane : '0;
      o_bit_idx  <= (state == s_xbar_compute) ? bit_cnt : '0;
      o_bit_last <= (state == s_xbar_compute) && (bit_cnt == last_bit);
      o_done     <= (state == s_xbar_done);

      case (state)
        s_xbar_idle: begin
          if (wr_accept && (o_wr_count < cnt_limit)) begin
            o_wr_count <= o_wr_count + cw'(1);
          end
          if (i_start) begin
            state   <= s_xbar_compute;
            bit_cnt <= '0;
          end
        end
        s_xbar_compute: begin
          if (bit_cnt == last_bit) begin
            state   <= s_xbar_done;
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + bw'(1);
          end
        end
        s_xbar_done: begin
          // Count clears together with the done pulse; start is ignored
          // here so a held start only retriggers from idle.
          o_wr_count <= '0;
          state      <= s_xbar_idle;
        end
        default: begin
          state <= s_xbar_idle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cim_xbar_ctrl.sv
// Directed testbench for cim_xbar_ctrl with default parameters
// (256 rows, 201 used, 8-bit elements). A byte-array model of the buffer
// supplies expected bit-planes; key values are also checked by hand.
module tb_cim_xbar_ctrl;

  localparam int xs = 256;
  localparam int dt = 8;

`ifdef CIM_XBAR_CLEAR_EN
  localparam logic clear_build = 1'b1;
`else
  localparam logic clear_build = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           i_cim_we;
  logic [7:0]     i_cim_addr;
  logic [dt-1:0]  i_data;
  logic           i_start;
  logic           o_cim_busy;
  logic           o_xbar_en;
  logic [xs-1:0]  o_xbar_row;
  logic [2:0]     o_bit_idx;
  logic           o_bit_last;
  logic           o_done;
  logic [8:0]     o_wr_count;

  logic [7:0]     model [xs];
  logic [xs-1:0]  planes [dt];
  int             n_cmp = 0;
  int             n_err = 0;

  cim_xbar_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .i_cim_we   (i_cim_we),
    .i_cim_addr (i_cim_addr),
    .i_data     (i_data),
    .i_start    (i_start),
    .o_cim_busy (o_cim_busy),
    .o_xbar_en  (o_xbar_en),
    .o_xbar_row (o_xbar_row),
    .o_bit_idx  (o_bit_idx),
    .o_bit_last (o_bit_last),
    .o_done     (o_done),
    .o_wr_count (o_wr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [xs-1:0] got,
                       input logic [xs-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input logic [7:0] data);
    i_cim_we   = 1'b1;
    i_cim_addr = 8'(addr);
    i_data     = data;
    model[addr] = data;
    tick();
    i_cim_we = 1'b0;
  endtask

  task automatic model_clear();
    for (int r = 0; r < xs; r++) model[r] = 8'h00;
  endtask

  // One full compute from idle. wr_at >= 0 drives a write (addr 0, data 0)
  // into that compute cycle; the model is left untouched since it must be
  // ignored. exp_cnt is the write count expected while computing.
  task automatic run_compute(input int wr_at, input logic [8:0] exp_cnt);
    logic [xs-1:0] exp_row;
    i_start = 1'b1;
    tick();                        // edge N: start sampled
    i_start  = 1'b0;
    i_cim_we = 1'b0;
    check("busy_at_N", o_cim_busy, 0);
    for (int k = 0; k < dt; k++) begin
      if (k == wr_at) begin
        i_cim_we   = 1'b1;
        i_cim_addr = 8'd0;
        i_data     = 8'h00;
      end
      tick();                      // edge N+1+k: plane k
      i_cim_we = 1'b0;
      exp_row = '0;
      for (int r = 0; r < xs; r++) exp_row[r] = model[r][k];
      planes[k] = o_xbar_row;
      check($sformatf("row_p%0d", k), o_xbar_row, exp_row);
      check($sformatf("bit_idx_p%0d", k), o_bit_idx, k);
      check($sformatf("last_p%0d", k), o_bit_last, (k == dt - 1));
      check($sformatf("en_busy_p%0d", k), {o_xbar_en, o_cim_busy}, 2'b11);
      if (k == 0) check("wr_count_at_start", o_wr_count, exp_cnt);
    end
    tick();                        // edge N+1+dt
    check("done_pulse", o_done, 1);
    check("busy_in_done", o_cim_busy, 1);
    check("en_off_in_done", o_xbar_en, 0);
    check("wr_count_cleared", o_wr_count, 0);
    tick();                        // edge N+2+dt
    check("done_low", o_done, 0);
    check("busy_fall", o_cim_busy, 0);
    if (clear_build) model_clear();
  endtask

  initial begin
    logic seen_done;
    int   wait_cnt;

    rst = 1'b1; i_cim_we = 1'b0; i_cim_addr = '0; i_data = '0; i_start = 1'b0;
    model_clear();
    tick(); tick();
    check("rst_busy", o_cim_busy, 0);
    check("rst_en", o_xbar_en, 0);
    check("rst_row", o_xbar_row, 0);
    check("rst_bit_idx", o_bit_idx, 0);
    check("rst_last_done", {o_bit_last, o_done}, 0);
    check("rst_wr_count", o_wr_count, 0);
    rst = 1'b0;
    tick();

    // Load and compute.
    wr(0, 8'hA5);
    wr(1, 8'hFF);
    wr(200, 8'h01);
    check("wr_count_3", o_wr_count, 3);
    run_compute(-1, 9'd3);
    check("hand_p0", {planes[0][200], planes[0][1], planes[0][0]}, 3'b111);
    check("hand_p1", {planes[1][200], planes[1][1], planes[1][0]}, 3'b010);
    check("hand_p7", {planes[7][200], planes[7][1], planes[7][0]}, 3'b011);

    // Write during busy is ignored; the following compute shows the
    // buffer unchanged (or cleared, in the clearing build).
    run_compute(3, 9'd0);
    check("busy_write_cnt", o_wr_count, 0);
    run_compute(-1, 9'd0);
    check("hand_p0_bit0_kept", planes[0][0], !clear_build);
    check("hand_p0_bit1_kept", planes[0][1], !clear_build);

    // Write accepted in the same cycle as start.
    i_cim_we = 1'b1; i_cim_addr = 8'd5; i_data = 8'h80;
    model[5] = 8'h80;
    run_compute(-1, 9'd1);
    check("hand_p7_bit5", planes[7][5], 1);
    check("hand_p6_bit5", planes[6][5], 0);

    // Held start: busy for dt+1 cycles, one idle cycle, then retrigger.
    i_start = 1'b1;
    tick();
    for (int c = 1; c <= dt + 1; c++) begin
      tick();
      check($sformatf("held_busy_c%0d", c), o_cim_busy, 1);
    end
    tick();
    check("held_idle_gap", o_cim_busy, 0);
    tick();
    check("held_retrigger", {o_cim_busy, o_xbar_en}, 2'b11);
    i_start = 1'b0;
    wait_cnt = 0;
    while (!o_done && wait_cnt < 20) begin
      tick();
      wait_cnt++;
    end
    check("held_done_seen", o_done, 1);
    tick();
    if (clear_build) model_clear();

    // Reset in the middle of a compute.
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    check("mid_plane3", o_bit_idx, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    check("mid_rst_busy_en", {o_cim_busy, o_xbar_en}, 2'b00);
    check("mid_rst_row", o_xbar_row, 0);
    seen_done = o_done;
    for (int c = 0; c < 12; c++) begin
      tick();
      seen_done |= o_done | o_cim_busy;
    end
    check("mid_rst_no_done", seen_done, 0);

    // Buffer zeroed by reset: compute with no writes sees all-zero planes.
    run_compute(-1, 9'd0);
    check("zero_after_rst_p0", planes[0], 0);

    // Write count saturates at input_size.
    for (int i = 0; i < 203; i++) wr(i, 8'(i));
    check("wr_count_sat", o_wr_count, 201);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
